// File: rtl/circ_smpl_queue.sv
`default_nettype none
// ============================================================================
// Module   : circ_smpl_queue
// Brief    : Decimating circular sample queue; streams the newest WINDOW
//            samples oldest-first after every stored sample.
// Revision : 1.0 - initial release
// ============================================================================
module circ_smpl_queue #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DECIM  = 2,
    parameter int WINDOW = 1021
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [DATA_W-1:0] new_smpl,
    input  logic              wrt_smpl,
    output logic [DATA_W-1:0] smpl_out,
    output logic              sequencing,
    output logic              seq_last,
    output logic              full,
    output logic              overrun,
    output logic [ADDR_W-1:0] fill_cnt
);

    localparam logic [1:0]        c_FILL    = 2'd0;
    localparam logic [1:0]        c_IDLE    = 2'd1;
    localparam logic [1:0]        c_READ    = 2'd2;
    localparam int                c_PH_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(DECIM - 1);
    localparam logic [ADDR_W-1:0] c_WIN     = ADDR_W'(WINDOW);
    localparam logic [ADDR_W-1:0] c_WIN_M1  = ADDR_W'(WINDOW - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_PH_W-1:0] r_phase;
    logic [ADDR_W-1:0] r_new_ptr;
    logic [ADDR_W-1:0] r_old_ptr;
    logic [ADDR_W-1:0] r_k;
    logic [ADDR_W-1:0] r_fill;
    logic              r_pending;
    logic              r_overrun;
    logic              r_seq;
    logic              r_last;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_acc;
    logic              w_issue;
    logic              w_issue_last;
    logic [ADDR_W-1:0] w_rd_addr;

    // clr overrides a coincident strobe: the sample is dropped
    assign w_acc     = wrt_smpl && (r_phase == c_PH_LAST) && !clr;
    assign w_rd_addr = r_old_ptr + r_k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_FILL: begin
                if (w_acc && (r_fill == c_WIN_M1)) begin
                    w_state_nxt = c_READ;
                end
            end
            c_IDLE: begin
                if (w_acc || r_pending) begin
                    w_state_nxt = c_READ;
                end
            end
            c_READ: begin
                // A write landing on the final issue chains straight into the next pass
                if (w_issue_last) begin
                    w_state_nxt = (r_pending || w_acc) ? c_READ : c_IDLE;
                end
            end
            default: w_state_nxt = c_FILL;
        endcase
        if (clr) begin
            w_state_nxt = c_FILL;
        end
    end

    always_comb begin
        w_issue      = (r_state == c_READ);
        w_issue_last = w_issue && (r_k == c_WIN_M1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase   <= '0;
            r_new_ptr <= '0;
            r_old_ptr <= '0;
            r_k       <= '0;
            r_fill    <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_seq     <= 1'b0;
            r_last    <= 1'b0;
        end else if (clr) begin
            r_phase   <= '0;
            r_new_ptr <= '0;
            r_old_ptr <= '0;
            r_k       <= '0;
            r_fill    <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_seq     <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            if (wrt_smpl) begin
                r_phase <= (r_phase == c_PH_LAST) ? '0 : r_phase + 1'b1;
            end
            if (w_acc) begin
                r_new_ptr <= r_new_ptr + 1'b1;
                if (r_fill != c_WIN) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
            if (w_issue_last) begin
                r_old_ptr <= r_old_ptr + 1'b1;
                r_k       <= '0;
                if (r_pending) begin
                    r_pending <= 1'b0;
                    if (w_acc) begin
                        r_overrun <= 1'b1;
                    end
                end
            end else begin
                if (w_issue) begin
                    r_k <= r_k + 1'b1;
                end
                if (w_issue && w_acc) begin
                    if (r_pending) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_pending <= 1'b1;
                    end
                end
            end
            r_seq  <= w_issue;
            r_last <= w_issue_last;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_mem[r_new_ptr] <= new_smpl;
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    assign smpl_out   = r_seq ? r_rd_data : '0;
    assign sequencing = r_seq;
    assign seq_last   = r_last;
    assign full       = (r_fill == c_WIN);
    assign overrun    = r_overrun;
    assign fill_cnt   = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_circ_smpl_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_circ_smpl_queue
// Brief    : Self-checking bench for circ_smpl_queue (DEPTH=16, WINDOW=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_circ_smpl_queue;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int DECIM  = 2;
    localparam int WINDOW = 4;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              clr      = 1'b0;
    logic [DATA_W-1:0] new_smpl = '0;
    logic              wrt_smpl = 1'b0;
    logic [DATA_W-1:0] smpl_out;
    logic              sequencing;
    logic              seq_last;
    logic              full;
    logic              overrun;
    logic [ADDR_W-1:0] fill_cnt;

    circ_smpl_queue #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DECIM(DECIM), .WINDOW(WINDOW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .new_smpl(new_smpl), .wrt_smpl(wrt_smpl),
        .smpl_out(smpl_out), .sequencing(sequencing), .seq_last(seq_last),
        .full(full), .overrun(overrun), .fill_cnt(fill_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int drop;
        int keep;
        int fill;
        bit seq;
        int e [4];
    } vec_t;

    vec_t vecs [10];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   hist [$];
    int   tl_w [12];
    int   tl_d [12];
    int   tl_s [12];
    int   tl_l [12];
    int   tl_e [12];
    int   w1   [4];
    int   w2   [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic strobe(input int d);
        @(negedge clk);
        new_smpl = d[15:0];
        wrt_smpl = 1'b1;
        @(negedge clk);
        wrt_smpl = 1'b0;
    endtask

    // Entered at the negedge of the cycle right after the accepted write
    task automatic check_seq(input int e [4], input string tag);
        chk({tag, " latency"}, sequencing, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk({tag, " seq"}, sequencing, 1);
            chk({tag, " data"}, smpl_out, e[i]);
            chk({tag, " last"}, seq_last, (i == 3) ? 1 : 0);
        end
        @(negedge clk);
        chk({tag, " end"}, sequencing, 0);
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            strobe(vecs[i].drop);
            strobe(vecs[i].keep);
            hist.push_back(vecs[i].keep);
            chk("vec fill_cnt", fill_cnt, vecs[i].fill);
            chk("vec full", full, (vecs[i].fill == WINDOW) ? 1 : 0);
            if (vecs[i].seq) begin
                check_seq(vecs[i].e, "vec");
            end else begin
                @(negedge clk);
                chk("vec no seq", sequencing, 0);
            end
        end
    endtask

    task automatic last4(output int w [4]);
        for (int j = 0; j < 4; j++) begin
            w[j] = hist[hist.size() - 4 + j];
        end
    endtask

    task automatic run_tl(input string tag);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk({tag, " seq"}, sequencing, tl_s[i]);
                chk({tag, " last"}, seq_last, tl_l[i]);
                if (tl_s[i] != 0) begin
                    chk({tag, " data"}, smpl_out, tl_e[i]);
                end
            end
            wrt_smpl = (tl_w[i] != 0);
            new_smpl = tl_d[i][15:0];
        end
    endtask

    initial begin
        int w [4];
        vecs[0] = '{1, 2, 1, 1'b0, '{0, 0, 0, 0}};
        vecs[1] = '{3, 4, 2, 1'b0, '{0, 0, 0, 0}};
        vecs[2] = '{5, 6, 3, 1'b0, '{0, 0, 0, 0}};
        vecs[3] = '{7, 8, 4, 1'b1, '{2, 4, 6, 8}};
        vecs[4] = '{9, 10, 4, 1'b1, '{4, 6, 8, 10}};
        vecs[5] = '{11, 12, 4, 1'b1, '{6, 8, 10, 12}};
        vecs[6] = '{31, 32, 1, 1'b0, '{0, 0, 0, 0}};
        vecs[7] = '{33, 34, 2, 1'b0, '{0, 0, 0, 0}};
        vecs[8] = '{35, 36, 3, 1'b0, '{0, 0, 0, 0}};
        vecs[9] = '{37, 38, 4, 1'b1, '{32, 34, 36, 38}};

        #12;
        chk("rst sequencing", sequencing, 0);
        chk("rst smpl_out", smpl_out, 0);
        chk("rst full", full, 0);
        chk("rst fill_cnt", fill_cnt, 0);
        chk("rst overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;

        apply(0, 5);

        // Long run: pointers wrap several times
        for (int i = 0; i < 40; i++) begin
            strobe((100 + i) ^ 16'h5555);
            strobe(100 + i);
            hist.push_back(100 + i);
            last4(w);
            check_seq(w, "wrap");
        end

        // One write mid-READ: second pass follows with no gap
        strobe(16'h7000);
        hist.push_back(200); last4(w1);
        hist.push_back(201); last4(w2);
        tl_w = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tl_d = '{200, 0, 16'h7001, 201, 0, 0, 0, 0, 0, 0, 0, 0};
        tl_s = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        tl_l = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
        tl_e = '{0, 0, w1[0], w1[1], w1[2], w1[3], w2[0], w2[1], w2[2], w2[3], 0, 0};
        run_tl("pend");
        chk("pend overrun", overrun, 0);

        // Two writes in one READ: overrun, only one extra pass
        strobe(16'h7002);
        hist.push_back(300); last4(w1);
        hist.push_back(301); last4(w2);
        hist.push_back(302);
        tl_w = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        tl_d = '{300, 16'h7003, 301, 16'h7004, 302, 0, 0, 0, 0, 0, 0, 0};
        tl_e = '{0, 0, w1[0], w1[1], w1[2], w1[3], w2[0], w2[1], w2[2], w2[3], 0, 0};
        run_tl("ovr");
        chk("ovr set", overrun, 1);
        repeat (5) @(negedge clk);
        chk("ovr sticky", overrun, 1);
        chk("ovr idle", sequencing, 0);

        // clr mid-sequence
        strobe(16'h7005);
        strobe(400);
        @(negedge clk);
        chk("clr pre seq", sequencing, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr seq", sequencing, 0);
        chk("clr last", seq_last, 0);
        chk("clr data", smpl_out, 0);
        chk("clr fill", fill_cnt, 0);
        chk("clr full", full, 0);
        chk("clr overrun", overrun, 0);

        // clr and strobe together: strobe ignored, phase untouched
        @(negedge clk);
        clr = 1'b1; wrt_smpl = 1'b1; new_smpl = 16'h77;
        @(negedge clk);
        clr = 1'b0; wrt_smpl = 1'b0;
        chk("clr+wrt fill", fill_cnt, 0);
        apply(6, 9);

        // Async reset mid-stream
        strobe(39);
        strobe(40);
        @(negedge clk);
        @(negedge clk);
        chk("mid data", smpl_out, 36);
        rst_n = 1'b0;
        #1;
        chk("arst seq", sequencing, 0);
        chk("arst data", smpl_out, 0);
        chk("arst last", seq_last, 0);
        chk("arst fill", fill_cnt, 0);
        chk("arst full", full, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post rst seq", sequencing, 0);
        chk("post rst fill", fill_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
